// File: rtl/scurve_scan_control.sv
// S-curve scan sequencer: steps the DAC threshold and channel, configures the
// ASIC for each point, fires the tester and frames its data into the USB FIFO.
//
// state     | meaning
// IDLE      | waiting for a Scan_Start rising edge
// WR_START  | write the start marker once the FIFO has room
// CONFIG    | raise Config_Req with the current dac/chn
// WAIT_CFG  | hold the request until Config_Done
// WR_HEADER | write the {chn, dac} point header once the FIFO has room
// FIRE      | one-cycle tester start, clear the word counter
// COLLECT   | forward tester words until One_Channel_Done
// NEXT      | advance channel, then DAC threshold
// WR_TAIL   | write the tail marker once the FIFO has room
// DONE      | one-cycle Scan_Done pulse
module scurve_scan_control #(
  parameter logic [15:0] START_MARK    = 16'h5A5A,
  parameter logic [15:0] TAIL_MARK     = 16'hA5A5,
  parameter int          WORDS_PER_CHN = 6
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        Scan_Start,
  input  logic [9:0]  Start_Dac,
  input  logic [9:0]  End_Dac,
  input  logic [9:0]  Dac_Step,
  input  logic        Single_Chn_Mode,
  input  logic [5:0]  Single_Chn_Sel,
  output logic [9:0]  Config_Dac,
  output logic [5:0]  Config_Chn,
  output logic        Config_Req,
  input  logic        Config_Done,
  output logic        SCurve_Test_Start,
  input  logic        One_Channel_Done,
  input  logic [15:0] SCurve_Data,
  input  logic        SCurve_Data_wr_en,
  input  logic        Out_Fifo_Full,
  output logic [15:0] Out_Data,
  output logic        Out_Data_wr_en,
  output logic        Scan_Done,
  output logic        Scan_Busy,
  output logic        Overflow,
  output logic        Count_Err
);

  localparam logic [3:0] WPC = 4'(WORDS_PER_CHN);

  typedef enum logic [3:0] {
    IDLE, WR_START, CONFIG, WAIT_CFG, WR_HEADER, FIRE, COLLECT, NEXT, WR_TAIL, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  dac_q, dac_d;
  logic [5:0]  chn_q, chn_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_wr_q, out_wr_d;
  logic        overflow_q, overflow_d;
  logic        cnt_err_q, cnt_err_d;
  logic        start_q;

  logic        start_rise;
  logic [10:0] dac_next;
  logic [3:0]  wcnt_inc;
  logic [3:0]  wcnt_at_done;

  assign start_rise   = Scan_Start & ~start_q;
  assign dac_next     = {1'b0, dac_q} + {1'b0, Dac_Step};
  // Saturate so a runaway tester cannot wrap the counter back onto a good value.
  assign wcnt_inc     = (wcnt_q == 4'hF) ? wcnt_q : wcnt_q + 4'd1;
  assign wcnt_at_done = SCurve_Data_wr_en ? wcnt_inc : wcnt_q;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dac_q      <= '0;
      chn_q      <= '0;
      wcnt_q     <= '0;
      out_data_q <= '0;
      out_wr_q   <= 1'b0;
      overflow_q <= 1'b0;
      cnt_err_q  <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dac_q      <= dac_d;
      chn_q      <= chn_d;
      wcnt_q     <= wcnt_d;
      out_data_q <= out_data_d;
      out_wr_q   <= out_wr_d;
      overflow_q <= overflow_d;
      cnt_err_q  <= cnt_err_d;
      start_q    <= Scan_Start;
    end
  end

  always_comb begin
    state_d    = state_q;
    dac_d      = dac_q;
    chn_d      = chn_q;
    wcnt_d     = wcnt_q;
    out_data_d = out_data_q;
    out_wr_d   = 1'b0;
    overflow_d = overflow_q;
    cnt_err_d  = cnt_err_q;

    // Abort wins over everything; a write registered last cycle still drains.
    if (state_q != IDLE && !Scan_Start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_rise) begin
            dac_d      = Start_Dac;
            chn_d      = Single_Chn_Mode ? Single_Chn_Sel : 6'd0;
            overflow_d = 1'b0;
            cnt_err_d  = 1'b0;
            state_d    = WR_START;
          end
        end
        WR_START: begin
          if (!Out_Fifo_Full) begin
            out_wr_d   = 1'b1;
            out_data_d = START_MARK;
            state_d    = (Start_Dac > End_Dac) ? WR_TAIL : CONFIG;
          end
        end
        CONFIG: state_d = Config_Done ? WR_HEADER : WAIT_CFG;
        WAIT_CFG: begin
          if (Config_Done) state_d = WR_HEADER;
        end
        WR_HEADER: begin
          if (!Out_Fifo_Full) begin
            out_wr_d   = 1'b1;
            out_data_d = {chn_q, dac_q};
            state_d    = FIRE;
          end
        end
        FIRE: begin
          wcnt_d  = '0;
          state_d = COLLECT;
        end
        COLLECT: begin
          if (SCurve_Data_wr_en) begin
            wcnt_d = wcnt_inc;
            if (Out_Fifo_Full) begin
              overflow_d = 1'b1;
            end else begin
              out_wr_d   = 1'b1;
              out_data_d = SCurve_Data;
            end
          end
          if (One_Channel_Done) begin
            if (wcnt_at_done != WPC) cnt_err_d = 1'b1;
            state_d = NEXT;
          end
        end
        NEXT: begin
          if (!Single_Chn_Mode && chn_q != 6'd63) begin
            chn_d   = chn_q + 6'd1;
            state_d = CONFIG;
          end else begin
            chn_d = Single_Chn_Mode ? Single_Chn_Sel : 6'd0;
            if (Dac_Step == 10'd0 || dac_next > {1'b0, End_Dac} || dac_next[10]) begin
              state_d = WR_TAIL;
            end else begin
              dac_d   = dac_next[9:0];
              state_d = CONFIG;
            end
          end
        end
        WR_TAIL: begin
          if (!Out_Fifo_Full) begin
            out_wr_d   = 1'b1;
            out_data_d = TAIL_MARK;
            state_d    = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign Config_Dac        = dac_q;
  assign Config_Chn        = chn_q;
  assign Config_Req        = (state_q == CONFIG) || (state_q == WAIT_CFG);
  assign SCurve_Test_Start = (state_q == FIRE) && Scan_Start;
  assign Scan_Done         = (state_q == DONE) && Scan_Start;
  assign Scan_Busy         = (state_q != IDLE);
  assign Out_Data          = out_data_q;
  assign Out_Data_wr_en    = out_wr_q;
  assign Overflow          = overflow_q;
  assign Count_Err         = cnt_err_q;

endmodule
